// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter that sequences a shared 4-bit-select bus-source decoder
// through a LOAD -> DRIVE -> RELEASE cycle, one granted requester at a time.
module bus_source_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int MAX_SEL     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*4-1:0] req_sel,
  output logic [NREQ-1:0]   grant,
  output logic [3:0]        dec_sel,
  output logic              dec_en_op,
  output logic              dec_en_out,
  output logic              done,
  output logic              err
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_DRIVE   = 3'd2,
    S_RELEASE = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [3:0]      cnt;
  logic [PW-1:0]   win;
  logic            found;
  logic [3:0]      win_code;
  logic            illegal;
  int              idx;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + PW'(1);
  endfunction

  // Round-robin search: first requesting index at or above the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign win_code = req_sel[4*win +: 4];
  assign illegal  = (32'(win_code) > MAX_SEL);

  // Sequencer; outputs are registered from the current state, so each phase
  // becomes visible one cycle after the state that produces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= 4'd0;
      grant      <= '0;
      dec_sel    <= 4'd0;
      dec_en_op  <= 1'b0;
      dec_en_out <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          grant      <= '0;
          dec_sel    <= 4'd0;
          dec_en_op  <= 1'b0;
          dec_en_out <= 1'b0;
          done       <= 1'b0;
          err        <= 1'b0;
          cnt        <= 4'd0;
          if (found) begin
            owner <= win;
            grant <= NREQ'(1) << win;
            if (illegal) begin
              err   <= 1'b1;
              state <= S_ERR;
            end else begin
              dec_sel <= win_code;
              state   <= S_LOAD;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          dec_en_op <= 1'b1;
          cnt       <= 4'd0;
          state     <= S_DRIVE;
        end
        S_DRIVE: begin
          dec_en_op  <= 1'b0;
          dec_en_out <= 1'b1;
          if (cnt == 4'(HOLD_CYCLES - 1)) begin
            state <= S_RELEASE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RELEASE: begin
          dec_en_out <= 1'b0;
          done       <= 1'b1;
          ptr        <= next_idx(owner);
          state      <= S_IDLE;
        end
        S_ERR: begin
          err   <= 1'b0;
          grant <= '0;
          ptr   <= next_idx(owner);
          state <= S_IDLE;
        end
        default: begin
          grant      <= '0;
          dec_sel    <= 4'd0;
          dec_en_op  <= 1'b0;
          dec_en_out <= 1'b0;
          done       <= 1'b0;
          err        <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Bench for bus_source_arbiter: hand-derived vector table, a fairness sequence and
// random traffic against a transaction-level reference model.
module tb_bus_source_arbiter;

  localparam int NREQ    = 4;
  localparam int HOLD    = 2;
  localparam int MAX_SEL = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_sel;
  logic [3:0]  grant;
  logic [3:0]  dec_sel;
  logic        dec_en_op, dec_en_out, done, err;

  bus_source_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .MAX_SEL(MAX_SEL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_sel(req_sel), .grant(grant),
    .dec_sel(dec_sel), .dec_en_op(dec_en_op), .dec_en_out(dec_en_out),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] sel;
    logic       op;
    logic       out;
    logic       dn;
    logic       er;
  } obs_t;

  typedef struct {
    logic        r;
    logic [3:0]  rq;
    logic [15:0] sl;
    obs_t        exp;
  } vec_t;

  vec_t tab[$];
  obs_t q[$];
  int   ptr = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  function automatic obs_t mk(input logic [3:0] g, input logic [3:0] s, input logic op,
                              input logic out, input logic dn, input logic er);
    obs_t o;
    o.grant = g; o.sel = s; o.op = op; o.out = out; o.dn = dn; o.er = er;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    return mk(grant, dec_sel, dec_en_op, dec_en_out, done, err);
  endfunction

  task automatic add(input logic r, input logic [3:0] rq, input logic [15:0] sl,
                     input logic [3:0] g, input logic [3:0] s, input logic op,
                     input logic out, input logic dn, input logic er);
    vec_t v;
    v.r = r; v.rq = rq; v.sl = sl; v.exp = mk(g, s, op, out, dn, er);
    tab.push_back(v);
  endtask

  task automatic check(input string name, input obs_t got, input obs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h, want %h (grant,sel,op,out,done,err)",
               name, cyc, got, want);
    end
  endtask

  // Reference: whenever no transfer is scheduled, arbitrate and queue the whole
  // expected output waveform of the resulting transfer.
  task automatic model_step(input logic r, input logic [3:0] rq, input logic [15:0] sl,
                            output obs_t e);
    int w;
    logic [3:0] code;
    logic [3:0] g;
    if (r) begin
      q.delete();
      ptr = 0;
      e = obs_t'(0);
    end else begin
      if (q.size() == 0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && rq[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
        if (w < 0) begin
          q.push_back(obs_t'(0));
        end else begin
          g = 4'b0001 << w;
          code = sl[4*w +: 4];
          if (code <= MAX_SEL) begin
            q.push_back(mk(g, code, 1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(mk(g, code, 1'b1, 1'b0, 1'b0, 1'b0));
            for (int h = 0; h < HOLD; h++) q.push_back(mk(g, code, 1'b0, 1'b1, 1'b0, 1'b0));
            q.push_back(mk(g, code, 1'b0, 1'b0, 1'b1, 1'b0));
          end else begin
            q.push_back(mk(g, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1));
            q.push_back(obs_t'(0));
          end
          ptr = (w + 1) % NREQ;
        end
      end
      e = q.pop_front();
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [15:0] sl);
    obs_t e;
    rst = r; req = rq; req_sel = sl;
    model_step(r, rq, sl, e);
    @(posedge clk);
    #1;
    cyc++;
    check("model", dut_obs(), e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gl[5];
    int ng;
    int ndone;
    logic [3:0] prev_g;
    logic prev_dn;
    rst = 1'b1; req = 4'b0000; req_sel = 16'h0000;

    // Reset, single transfer with req dropped in DRIVE, illegal code,
    // wrap-around, req dropped in LOAD, reset in the second DRIVE cycle.
    add(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'b0010, 16'h0050, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b0010, 16'h0050, 4'b0010, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b0010, 16'h0050, 4'b0010, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 16'h0050, 4'b0010, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 16'h0000, 4'b0010, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 16'h0000, 4'b0010, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b0100, 16'h0C00, 4'b0100, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 16'h0C00, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b1001, 16'h2003, 4'b1000, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b1001, 16'h2003, 4'b1000, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b1001, 16'h2003, 4'b1000, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'b1001, 16'h2003, 4'b1000, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'b1001, 16'h2003, 4'b1000, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 4'b0001, 16'h2003, 4'b0001, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 16'h2003, 4'b0001, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 16'h0000, 4'b0001, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 16'h0000, 4'b0001, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 16'h0000, 4'b0001, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b0001, 16'h0007, 4'b0001, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b0001, 16'h0007, 4'b0001, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b0001, 16'h0007, 4'b0001, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 4'b0001, 16'h0007, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b0011, 16'h0047, 4'b0001, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 16'h0047, 4'b0001, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 16'h0000, 4'b0001, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 16'h0000, 4'b0001, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 16'h0000, 4'b0001, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i].r, tab[i].rq, tab[i].sl);
      check($sformatf("table[%0d]", i), dut_obs(), tab[i].exp);
    end

    // Fairness: all four requesters held high must be served in index order.
    step(1'b1, 4'b0000, 16'h0000);
    ng = 0; ndone = 0; prev_g = 4'b0000; prev_dn = 1'b0;
    for (int i = 0; i < 5; i++) gl[i] = -1;
    for (int c = 0; c < 25; c++) begin
      step(1'b0, 4'b1111, 16'h3210);
      if (grant != 4'b0000 && (prev_g == 4'b0000 || prev_dn) && ng < 5) begin
        gl[ng] = int'(grant);
        ng++;
      end
      if (done) ndone++;
      prev_g = grant; prev_dn = done;
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (gl[i] != (1 << (i % 4))) begin
        miscompares++;
        $display("FAIL fair_order[%0d]: got grant %0d, want %0d", i, gl[i], 1 << (i % 4));
      end
    end
    vectors++;
    if (ndone != 5) begin
      miscompares++;
      $display("FAIL fair_done_count: got %0d, want 5", ndone);
    end

    // Random traffic, including illegal codes and occasional resets.
    step(1'b1, 4'b0000, 16'h0000);
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4-bit-select, 12-output bus-source decoder.
- Accepts bus-source requests from NREQ requesters, each supplying a 4-bit source code.
- Grants one requester at a time and drives the decoder select and enables in a fixed LOAD -> DRIVE -> RELEASE sequence.
- Result: exactly one decoder output is enabled per transfer, and the decoder is never re-selected while it is driving.

Parameters:
- NREQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 2, cycles the decoder output enable stays high per transfer (1..15).
- MAX_SEL, 11, highest legal source code; codes above it are rejected.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  request per requester; held high until done or err for that requester.
- req_sel  input  NREQ*4  source code per requester; requester i uses bits [4i+3:4i]; stable while req[i] is high.
- grant  output  NREQ  one-hot; the current owner of the decoder.
- dec_sel  output  4  source code to the decoder select.
- dec_en_op  output  1  decoder select-latch enable.
- dec_en_out  output  1  decoder output enable.
- done  output  1  one-cycle pulse when the granted transfer completes.
- err  output  1  one-cycle pulse when the arbitrated request carried an illegal code.

Behaviour:
- Reset (synchronous): state=IDLE; outputs grant=0, dec_sel=0, dec_en_op=0, dec_en_out=0, done=0, err=0.
  - Reset also sets the round-robin pointer to 0 and the hold counter to 0.
  - Reset asserted in any state forces these values at the next rising edge, aborting any transfer; no done is produced.
- Outputs are registered. State machine:
  - IDLE: all outputs 0. If any req bit is high, pick the winner by round-robin (see arbitration).
    - If the winner's code <= MAX_SEL: go to LOAD. Register grant=one-hot(winner) and dec_sel=code.
    - If the winner's code > MAX_SEL: go to ERR.
  - LOAD (1 cycle): grant and dec_sel held; dec_en_op=1, dec_en_out=0. Go to DRIVE.
  - DRIVE (HOLD_CYCLES cycles): dec_en_op=0, dec_en_out=1; grant and dec_sel held. The hold counter counts from 0 to HOLD_CYCLES-1, then the state goes to RELEASE.
  - RELEASE (1 cycle): dec_en_out=0, done=1, grant still asserted. Pointer is set to winner+1 (mod NREQ). Go to IDLE.
  - ERR (1 cycle): err=1, grant=one-hot(winner), dec_en_op=0, dec_en_out=0, dec_sel=0. Pointer is set to winner+1 (mod NREQ). Go to IDLE.
- Arbitration:
  - Search starts at the pointer index and proceeds upward with wrap-around; the first requester with req high wins.
  - The pointer changes only in RELEASE and ERR.
- Latency: req seen in IDLE -> grant at the next edge. Each transfer occupies HOLD_CYCLES+3 cycles (IDLE decision, LOAD, DRIVE, RELEASE) before the next arbitration. An error occupies 2 cycles.
- Back-to-back requests: there is always one IDLE cycle between transfers, with all enables low.
- req dropped mid-transfer:
  - The transfer completes normally and done is still pulsed.
  - Changes on req and req_sel are ignored outside IDLE.
- dec_en_op and dec_en_out are never high in the same cycle. At most one grant bit is high.
- A requester must not re-raise req in the cycle done/err is pulsed for it. If req is still high in the following IDLE cycle, it counts as a new request.

Test Plan:
- Single requester, HOLD_CYCLES=2: req[1]=1, sel1=4'h5.
  - Cycle 1: grant=0010, dec_sel=5. Cycle 2: en_op=1. Cycles 3-4: en_out=1. Cycle 5: done=1.
  - Then idle with all outputs 0.
- Illegal code: req[2]=1, sel2=4'hC.
  - err=1 for one cycle with grant=0100. en_op and en_out stay 0 throughout. No done.
  - Pointer becomes 3.
- Fairness: req=1111 held continuously, codes 0..3.
  - Grants occur in order 0001, 0010, 0100, 1000, 0001.
  - Exactly one done per grant; an IDLE gap precedes each grant.
- Wrap-around: pointer=3 (after serving req 2), req=1001.
  - Requester 3 is granted first, then requester 0.
- Reset mid-operation: rst=1 during the second DRIVE cycle.
  - Next edge: every output 0, state IDLE, no done pulse.
  - After rst drops with req[0] high: requester 0 is granted (pointer reset to 0).
- req dropped in LOAD: the transfer still completes with the full en_out window and a done pulse. The next IDLE grants no one if req=0.
